// File: rtl/vm_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vm_request_sequencer
// Purpose  : Front-end controller for the vending machine FSM. It turns raw
//            coin/coffee/sprite levels into rising-edge requests and holds
//            them in one-deep pending flags. It grants one request at a time
//            as a single-cycle pulse, then waits for the vending FSM to react.
//            When the FSM reports a product-out condition, it runs a timed
//            dispense-motor pulse and blocks further grants until it ends.
// Ports    : clk, rst (sync, active-high)
//            i_coin_raw, i_coffee_raw, i_sprite_raw : raw input levels
//            i_vm_coffee, i_vm_sprite               : product-out from FSM
//            o_coin, o_coffee, o_sprite             : one-cycle grant pulses
//            o_motor_coffee, o_motor_sprite         : dispense motor drives
//            o_busy                                 : sequencer not idle
//            o_drop                                 : a request was lost
// Revision : 1.0 - initial release
// ============================================================================
module vm_request_sequencer #(
    parameter int GAP_CYC   = 2,
    parameter int MOTOR_CYC = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_coin_raw,
    input  logic i_coffee_raw,
    input  logic i_sprite_raw,
    input  logic i_vm_coffee,
    input  logic i_vm_sprite,
    output logic o_coin,
    output logic o_coffee,
    output logic o_sprite,
    output logic o_motor_coffee,
    output logic o_motor_sprite,
    output logic o_busy,
    output logic o_drop
);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_ISSUE    = 2'd1;
    localparam logic [1:0] c_S_WAIT     = 2'd2;
    localparam logic [1:0] c_S_DISPENSE = 2'd3;

    localparam logic [1:0] c_G_COIN   = 2'd0;
    localparam logic [1:0] c_G_COFFEE = 2'd1;
    localparam logic [1:0] c_G_SPRITE = 2'd2;

    localparam logic [CNT_W-1:0] c_GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_MOTOR_LOAD = CNT_W'(MOTOR_CYC - 1);

    logic             r_prev_coin, r_prev_coffee, r_prev_sprite;
    logic             r_pend_coin, r_pend_coffee, r_pend_sprite;
    logic [1:0]       r_state, w_state_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_coin, r_coffee, r_sprite;
    logic             w_coin_nxt, w_coffee_nxt, w_sprite_nxt;
    logic             r_motor_coffee, r_motor_sprite;
    logic             w_motor_coffee_nxt, w_motor_sprite_nxt;
    logic             r_busy, r_drop;

    logic w_rise_coin, w_rise_coffee, w_rise_sprite;
    logic w_gnt_coin, w_gnt_coffee, w_gnt_sprite;
    logic w_drop;

    assign w_rise_coin   = i_coin_raw   & ~r_prev_coin;
    assign w_rise_coffee = i_coffee_raw & ~r_prev_coffee;
    assign w_rise_sprite = i_sprite_raw & ~r_prev_sprite;

    // A source counts as granted during the ISSUE cycle; its pend clears at
    // the end of that cycle unless a fresh press arrives at the same time.
    assign w_gnt_coin   = (r_state == c_S_ISSUE) && (r_grant == c_G_COIN);
    assign w_gnt_coffee = (r_state == c_S_ISSUE) && (r_grant == c_G_COFFEE);
    assign w_gnt_sprite = (r_state == c_S_ISSUE) && (r_grant == c_G_SPRITE);

    // Any press arriving on an already-pending, non-granted source is lost;
    // several at once collapse into one pulse.
    assign w_drop = (w_rise_coin   & r_pend_coin   & ~w_gnt_coin)   |
                    (w_rise_coffee & r_pend_coffee & ~w_gnt_coffee) |
                    (w_rise_sprite & r_pend_sprite & ~w_gnt_sprite);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_S_IDLE;
            r_grant        <= c_G_COIN;
            r_cnt          <= '0;
            // History starts high so a level held through reset is ignored.
            r_prev_coin    <= 1'b1;
            r_prev_coffee  <= 1'b1;
            r_prev_sprite  <= 1'b1;
            r_pend_coin    <= 1'b0;
            r_pend_coffee  <= 1'b0;
            r_pend_sprite  <= 1'b0;
            r_coin         <= 1'b0;
            r_coffee       <= 1'b0;
            r_sprite       <= 1'b0;
            r_motor_coffee <= 1'b0;
            r_motor_sprite <= 1'b0;
            r_busy         <= 1'b0;
            r_drop         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_cnt          <= w_cnt_nxt;
            r_prev_coin    <= i_coin_raw;
            r_prev_coffee  <= i_coffee_raw;
            r_prev_sprite  <= i_sprite_raw;
            r_pend_coin    <= w_rise_coin   | (r_pend_coin   & ~w_gnt_coin);
            r_pend_coffee  <= w_rise_coffee | (r_pend_coffee & ~w_gnt_coffee);
            r_pend_sprite  <= w_rise_sprite | (r_pend_sprite & ~w_gnt_sprite);
            r_coin         <= w_coin_nxt;
            r_coffee       <= w_coffee_nxt;
            r_sprite       <= w_sprite_nxt;
            r_motor_coffee <= w_motor_coffee_nxt;
            r_motor_sprite <= w_motor_sprite_nxt;
            r_busy         <= (w_state_nxt != c_S_IDLE);
            r_drop         <= w_drop;
        end
    end

    // Next-state and next-output logic. The grant pulse is registered on the
    // transition into ISSUE so it is high exactly during the ISSUE cycle.
    always_comb begin
        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_cnt_nxt          = r_cnt;
        w_coin_nxt         = 1'b0;
        w_coffee_nxt       = 1'b0;
        w_sprite_nxt       = 1'b0;
        w_motor_coffee_nxt = r_motor_coffee;
        w_motor_sprite_nxt = r_motor_sprite;

        case (r_state)
            c_S_IDLE: begin
                if (r_pend_coin) begin
                    w_grant_nxt = c_G_COIN;
                    w_coin_nxt  = 1'b1;
                    w_state_nxt = c_S_ISSUE;
                end else if (r_pend_coffee) begin
                    w_grant_nxt  = c_G_COFFEE;
                    w_coffee_nxt = 1'b1;
                    w_state_nxt  = c_S_ISSUE;
                end else if (r_pend_sprite) begin
                    w_grant_nxt  = c_G_SPRITE;
                    w_sprite_nxt = 1'b1;
                    w_state_nxt  = c_S_ISSUE;
                end
            end

            c_S_ISSUE: begin
                w_cnt_nxt   = c_GAP_LOAD;
                w_state_nxt = c_S_WAIT;
            end

            c_S_WAIT: begin
                if (i_vm_coffee) begin
                    w_motor_coffee_nxt = 1'b1;
                    w_cnt_nxt          = c_MOTOR_LOAD;
                    w_state_nxt        = c_S_DISPENSE;
                end else if (i_vm_sprite) begin
                    w_motor_sprite_nxt = 1'b1;
                    w_cnt_nxt          = c_MOTOR_LOAD;
                    w_state_nxt        = c_S_DISPENSE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            c_S_DISPENSE: begin
                if (r_cnt == '0) begin
                    w_motor_coffee_nxt = 1'b0;
                    w_motor_sprite_nxt = 1'b0;
                    w_state_nxt        = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign o_coin         = r_coin;
    assign o_coffee       = r_coffee;
    assign o_sprite       = r_sprite;
    assign o_motor_coffee = r_motor_coffee;
    assign o_motor_sprite = r_motor_sprite;
    assign o_busy         = r_busy;
    assign o_drop         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_vm_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_request_sequencer
// Purpose  : Self-checking bench for vm_request_sequencer. A table of
//            per-cycle {inputs, expected outputs} records is applied one
//            clock at a time, followed by a hand-written sequence for
//            simultaneous drops and queued service order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vm_request_sequencer;

    logic clk;
    logic rst;
    logic coin_raw, coffee_raw, sprite_raw, vm_coffee, vm_sprite;
    logic o_coin, o_coffee, o_sprite, o_motor_coffee, o_motor_sprite;
    logic o_busy, o_drop;

    int checks = 0;
    int errors = 0;

    // in : {rst, coin, coffee, sprite, vm_coffee, vm_sprite}
    // exp: {coin, coffee, sprite, motor_coffee, motor_sprite, busy, drop}
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    vm_request_sequencer #(
        .GAP_CYC   (2),
        .MOTOR_CYC (8),
        .CNT_W     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_coin_raw     (coin_raw),
        .i_coffee_raw   (coffee_raw),
        .i_sprite_raw   (sprite_raw),
        .i_vm_coffee    (vm_coffee),
        .i_vm_sprite    (vm_sprite),
        .o_coin         (o_coin),
        .o_coffee       (o_coffee),
        .o_sprite       (o_sprite),
        .o_motor_coffee (o_motor_coffee),
        .o_motor_sprite (o_motor_sprite),
        .o_busy         (o_busy),
        .o_drop         (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic add(input logic [5:0] in, input logic [6:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive inputs mid-period, then sample #1 after the next rising edge.
    task automatic apply(input logic [5:0] in);
        @(negedge clk);
        {rst, coin_raw, coffee_raw, sprite_raw, vm_coffee, vm_sprite} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {o_coin, o_coffee, o_sprite, o_motor_coffee, o_motor_sprite,
               o_busy, o_drop};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (coin,coffee,sprite,mc,ms,busy,drop)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply a held input pattern until the selected output goes high, with a
    // cycle budget. Returns the number of cycles taken (budget+1 on timeout).
    task automatic wait_for(input logic [5:0] in, input int sel, input int budget,
                            output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n <= budget) begin
            apply(in);
            n++;
            case (sel)
                0:       hit = o_coin;
                1:       hit = o_coffee;
                default: hit = o_sprite;
            endcase
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        coin_raw   = 1'b0;
        coffee_raw = 1'b1;
        sprite_raw = 1'b0;
        vm_coffee  = 1'b0;
        vm_sprite  = 1'b0;

        // Coffee held through reset: no request until it is released and re-pressed.
        add(6'b101000, 7'b0000000);
        add(6'b001000, 7'b0000000);
        add(6'b001000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        add(6'b001000, 7'b0000000);
        add(6'b000000, 7'b0100010);
        add(6'b000000, 7'b0000010);
        add(6'b000000, 7'b0000010);
        add(6'b000000, 7'b0000000);
        // Coin and coffee rise together: coin first, coffee after the gap.
        add(6'b011000, 7'b0000000);
        add(6'b011000, 7'b1000010);
        add(6'b011000, 7'b0000010);
        add(6'b011000, 7'b0000010);
        add(6'b011000, 7'b0000000);
        add(6'b011000, 7'b0100010);
        add(6'b011000, 7'b0000010);
        add(6'b011000, 7'b0000010);
        add(6'b011000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        // Coffee grant then product-out in first WAIT cycle: 8-cycle motor.
        add(6'b001000, 7'b0000000);
        add(6'b000000, 7'b0100010);
        add(6'b000000, 7'b0000010);
        add(6'b000010, 7'b0001010);
        add(6'b000010, 7'b0001010);
        for (int i = 0; i < 6; i++) add(6'b000000, 7'b0001010);
        add(6'b000000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        // Second sprite press while sprite pending and busy: one drop, one grant.
        add(6'b010100, 7'b0000000);
        add(6'b010000, 7'b1000010);
        add(6'b010100, 7'b0000011);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000000);
        add(6'b010000, 7'b0010010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000000);
        add(6'b010000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        // Coin press in its own ISSUE cycle is kept and served again.
        add(6'b010000, 7'b0000000);
        add(6'b000000, 7'b1000010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000000);
        add(6'b010000, 7'b1000010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000010);
        add(6'b010000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        // Reset during sprite dispense after 3 motor cycles; pending coffee is lost.
        add(6'b000100, 7'b0000000);
        add(6'b001000, 7'b0010010);
        add(6'b000000, 7'b0000010);
        add(6'b000001, 7'b0000110);
        add(6'b000000, 7'b0000110);
        add(6'b000000, 7'b0000110);
        add(6'b100000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        add(6'b000000, 7'b0000000);
        add(6'b000000, 7'b0000000);

        foreach (vecs[i]) begin
            apply(vecs[i].in);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hand-written: three presses at once, re-pressed during the coin
        // ISSUE cycle -> coin kept, coffee+sprite lost as one drop pulse,
        // then service order coin, coffee, sprite each 4 cycles apart.
        apply(6'b011100);
        check_outs("multi_press", 7'b0000000);
        apply(6'b000000);
        check_outs("multi_grant_coin", 7'b1000010);
        apply(6'b011100);
        check_outs("multi_drop", 7'b0000011);
        apply(6'b011100);
        check_outs("multi_drop_single", 7'b0000010);
        wait_for(6'b011100, 0, 10, n);
        check_int("requeued_coin_latency", n, 2);
        wait_for(6'b011100, 1, 10, n);
        check_int("coffee_after_coin", n, 4);
        wait_for(6'b011100, 2, 10, n);
        check_int("sprite_after_coffee", n, 4);
        for (int i = 0; i < 4; i++) apply(6'b011100);
        check_outs("all_served_idle", 7'b0000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
